// File: rtl/dispatch_queue_pkg.sv
// dispatch_queue_pkg: shared widths, payload types and CDB match helper for the dispatch stage
package dispatch_queue_pkg;
   localparam int PREG_W  = 7;
   localparam int ROB_W   = 5;
   localparam int NUM_CDB = 3;

   typedef struct packed {
      logic [31:0]       pc;
      logic [6:0]        opcode;
      logic [2:0]        func3;
      logic [6:0]        func7;
      logic [31:0]       imm;
      logic [PREG_W-1:0] ps1;
      logic [PREG_W-1:0] ps2;
      logic [PREG_W-1:0] pd_new;
      logic [PREG_W-1:0] pd_old;
   } rename_data;

   typedef struct packed {
      logic [31:0]       pc;
      logic [6:0]        opcode;
      logic [2:0]        func3;
      logic [6:0]        func7;
      logic [31:0]       imm;
      logic [PREG_W-1:0] prd;
      logic [PREG_W-1:0] pr1;
      logic [PREG_W-1:0] pr2;
      logic [ROB_W-1:0]  rob_index;
      logic              pr1_ready;
      logic              pr2_ready;
   } dispatch_pipeline_data;

   function automatic logic cdb_hit(input logic [PREG_W-1:0] tag, input logic [NUM_CDB-1:0] cdb_valid,
                                    input logic [NUM_CDB*PREG_W-1:0] cdb_tag);
      logic h;
      h = 1'b0;
      for (int i = 0; i < NUM_CDB; i++) h = h | (cdb_valid[i] && cdb_tag[i*PREG_W +: PREG_W] == tag);
      return h;
   endfunction
endpackage

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if: rename, wakeup, reservation-station and ROB signals of the dispatch stage
interface dispatch_queue_if
   import dispatch_queue_pkg::*;
#(parameter int NUM_FU = 3);
   logic                      valid_in;
   rename_data                data_in;
   logic [NUM_FU-1:0]         fu_sel_in;
   logic                      ready_in;
   logic [PREG_W-1:0]         query_ps1;
   logic [PREG_W-1:0]         query_ps2;
   logic                      pr1_is_ready;
   logic                      pr2_is_ready;
   logic                      nr_valid_out;
   logic [PREG_W-1:0]         nr_reg_out;
   logic [NUM_CDB-1:0]        cdb_valid;
   logic [NUM_CDB*PREG_W-1:0] cdb_tag;
   logic [NUM_FU-1:0]         rs_valid_out;
   dispatch_pipeline_data     rs_data_out;
   logic [NUM_FU-1:0]         rs_ready_in;
   logic                      rob_we_out;
   logic [PREG_W-1:0]         rob_pd_new_out;
   logic [PREG_W-1:0]         rob_pd_old_out;
   logic [31:0]               rob_pc_out;
   logic [ROB_W-1:0]          rob_tag_in;
   logic                      rob_full_in;
   logic                      mispredict;

   modport slave (
      input  valid_in, data_in, fu_sel_in, pr1_is_ready, pr2_is_ready, cdb_valid, cdb_tag,
             rs_ready_in, rob_tag_in, rob_full_in, mispredict,
      output ready_in, query_ps1, query_ps2, nr_valid_out, nr_reg_out, rs_valid_out, rs_data_out,
             rob_we_out, rob_pd_new_out, rob_pd_old_out, rob_pc_out
   );

   modport master (
      output valid_in, data_in, fu_sel_in, pr1_is_ready, pr2_is_ready, cdb_valid, cdb_tag,
             rs_ready_in, rob_tag_in, rob_full_in, mispredict,
      input  ready_in, query_ps1, query_ps2, nr_valid_out, nr_reg_out, rs_valid_out, rs_data_out,
             rob_we_out, rob_pd_new_out, rob_pd_old_out, rob_pc_out
   );
endinterface

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order circular dispatch queue with CDB wakeup snooping and ROB allocation
module dispatch_queue
   import dispatch_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int NUM_FU = 3
) (
   input logic clk,
   input logic reset,
   dispatch_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   rename_data        q_data [DEPTH];
   logic [NUM_FU-1:0] q_fu [DEPTH];
   logic [DEPTH-1:0]  q_r1, q_r2;
   logic [PW-1:0]     head, tail;
   logic [CW-1:0]     count;
   logic              has_head, rs_ok, enq, deq;
   logic [NUM_FU-1:0] hd_fu, sel;
   rename_data        hd;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   // head decode, handshakes and strobes; head is hidden while reset is high
   always_comb begin
      has_head = count != '0 && !reset;
      hd = has_head ? q_data[head] : '0;
      hd_fu = has_head ? q_fu[head] : '0;
      sel = hd_fu & (~hd_fu + 1'b1);
      rs_ok = hd_fu == '0 || (sel & bus.rs_ready_in) != '0;
      deq = has_head && !bus.rob_full_in && !bus.mispredict && rs_ok;
      bus.ready_in = count != CW'(DEPTH) && !reset && !bus.mispredict;
      enq = bus.valid_in && bus.ready_in;
      bus.query_ps1 = bus.data_in.ps1;
      bus.query_ps2 = bus.data_in.ps2;
      bus.nr_valid_out = enq && bus.data_in.pd_new != '0;
      bus.nr_reg_out = bus.data_in.pd_new;
      bus.rs_valid_out = deq ? sel : '0;
      bus.rob_we_out = deq;
      bus.rob_pd_new_out = hd.pd_new;
      bus.rob_pd_old_out = hd.pd_old;
      bus.rob_pc_out = hd.pc;
      bus.rs_data_out = '{pc: hd.pc, opcode: hd.opcode, func3: hd.func3, func7: hd.func7, imm: hd.imm,
                          prd: hd.pd_new, pr1: hd.ps1, pr2: hd.ps2,
                          rob_index: has_head ? bus.rob_tag_in : '0,
                          pr1_ready: has_head && (q_r1[head] || cdb_hit(hd.ps1, bus.cdb_valid, bus.cdb_tag)),
                          pr2_ready: has_head && (q_r2[head] || cdb_hit(hd.ps2, bus.cdb_valid, bus.cdb_tag))};
   end

   // queue storage, pointers and per-entry wakeup; a new entry's readiness overrides the snoop
   always_ff @(posedge clk) begin
      if (reset || bus.mispredict) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit(q_data[i].ps1, bus.cdb_valid, bus.cdb_tag)) q_r1[i] <= 1'b1;
            if (cdb_hit(q_data[i].ps2, bus.cdb_valid, bus.cdb_tag)) q_r2[i] <= 1'b1;
         end
         if (enq) begin
            q_data[tail] <= bus.data_in;
            q_fu[tail] <= bus.fu_sel_in;
            q_r1[tail] <= bus.data_in.ps1 == '0 || bus.pr1_is_ready || cdb_hit(bus.data_in.ps1, bus.cdb_valid, bus.cdb_tag);
            q_r2[tail] <= bus.data_in.ps2 == '0 || bus.pr2_is_ready || cdb_hit(bus.data_in.ps2, bus.cdb_valid, bus.cdb_tag);
            tail <= nxt(tail);
         end
         if (deq) head <= nxt(head);
         count <= count + CW'(enq) - CW'(deq);
      end
   end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: table-driven directed checks plus flush, reset and wrap sequences
module tb_dispatch_queue;
   import dispatch_queue_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dispatch_queue_if #(.NUM_FU(3)) bus ();
   dispatch_queue #(.DEPTH(4), .NUM_FU(3)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      int v, pc, ps1, ps2, pd, fu, rsr, rf, cv, ct, pr1, pr2;
      int e_rdy, e_rsv, e_we, e_pc, e_nr, e_r1, e_r2;
   } vec_t;

   vec_t tv [30];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t, input int tag);
      bus.valid_in = t.v != 0;
      bus.data_in = '0;
      bus.data_in.pc = 32'(t.pc);
      bus.data_in.opcode = 7'h33;
      bus.data_in.imm = 32'(t.pc) + 32'd4;
      bus.data_in.ps1 = 7'(t.ps1);
      bus.data_in.ps2 = 7'(t.ps2);
      bus.data_in.pd_new = 7'(t.pd);
      bus.data_in.pd_old = 7'(t.pd + 1);
      bus.fu_sel_in = 3'(t.fu);
      bus.rs_ready_in = 3'(t.rsr);
      bus.rob_full_in = t.rf != 0;
      bus.cdb_valid = 3'(t.cv);
      bus.cdb_tag = 21'(t.ct);
      bus.pr1_is_ready = t.pr1 != 0;
      bus.pr2_is_ready = t.pr2 != 0;
      bus.rob_tag_in = 5'(tag);
      bus.mispredict = 1'b0;
   endtask

   function automatic vec_t mkv(input int v, input int pc, input int fu, input int rsr, input int rf);
      vec_t t;
      t = '{default: 0};
      t.v = v;
      t.pc = pc;
      t.pd = 3;
      t.fu = fu;
      t.rsr = rsr;
      t.rf = rf;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //        v  pc     ps1 ps2 pd fu rsr rf cv ct        pr1 pr2  rdy rsv we pc     nr r1 r2
      tv[0]  = '{1, 'h100, 5,  0,  9, 1, 0,  0, 0, 0,        0,  0,   1,  0,  0, 0,     1, 0, 0};
      tv[1]  = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  0, 'h100, 0, 0, 1};
      tv[2]  = '{0, 0,     0,  0,  0, 0, 0,  0, 1, 5,        0,  0,   1,  0,  0, 'h100, 0, 1, 1};
      tv[3]  = '{0, 0,     0,  0,  0, 0, 1,  0, 0, 0,        0,  0,   1,  1,  1, 'h100, 0, 1, 1};
      tv[4]  = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  0, 0,     0, 0, 0};
      tv[5]  = '{1, 'h200, 0,  0,  0, 0, 0,  1, 0, 0,        0,  0,   1,  0,  0, 0,     0, 0, 0};
      tv[6]  = '{1, 'h210, 0,  0, 10, 0, 0,  1, 0, 0,        0,  0,   1,  0,  0, 'h200, 1, 1, 1};
      tv[7]  = '{1, 'h220, 0,  0, 11, 0, 0,  1, 0, 0,        0,  0,   1,  0,  0, 'h200, 1, 1, 1};
      tv[8]  = '{1, 'h230, 0,  0, 12, 0, 0,  1, 0, 0,        0,  0,   1,  0,  0, 'h200, 1, 1, 1};
      tv[9]  = '{1, 'h240, 0,  0, 13, 0, 0,  1, 0, 0,        0,  0,   0,  0,  0, 'h200, 0, 1, 1};
      tv[10] = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   0,  0,  1, 'h200, 0, 1, 1};
      tv[11] = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  1, 'h210, 0, 1, 1};
      tv[12] = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  1, 'h220, 0, 1, 1};
      tv[13] = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  1, 'h230, 0, 1, 1};
      tv[14] = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  0, 0,     0, 0, 0};
      tv[15] = '{1, 'h300, 0,  0, 14, 2, 5,  0, 0, 0,        0,  0,   1,  0,  0, 0,     1, 0, 0};
      tv[16] = '{1, 'h310, 0,  0, 15, 1, 5,  0, 0, 0,        0,  0,   1,  0,  0, 'h300, 1, 1, 1};
      tv[17] = '{0, 0,     0,  0,  0, 0, 5,  0, 0, 0,        0,  0,   1,  0,  0, 'h300, 0, 1, 1};
      tv[18] = '{0, 0,     0,  0,  0, 0, 7,  0, 0, 0,        0,  0,   1,  2,  1, 'h300, 0, 1, 1};
      tv[19] = '{0, 0,     0,  0,  0, 0, 7,  0, 0, 0,        0,  0,   1,  1,  1, 'h310, 0, 1, 1};
      tv[20] = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  0, 0,     0, 0, 0};
      tv[21] = '{1, 'h400, 0,  0, 16, 6, 0,  0, 0, 0,        0,  0,   1,  0,  0, 0,     1, 0, 0};
      tv[22] = '{0, 0,     0,  0,  0, 0, 4,  0, 0, 0,        0,  0,   1,  0,  0, 'h400, 0, 1, 1};
      tv[23] = '{0, 0,     0,  0,  0, 0, 2,  0, 0, 0,        0,  0,   1,  2,  1, 'h400, 0, 1, 1};
      tv[24] = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  0, 0,     0, 0, 0};
      tv[25] = '{1, 'h700, 20, 21, 17, 1, 0,  0, 4, (20<<14), 0,  1,   1,  0,  0, 0,     1, 0, 0};
      tv[26] = '{1, 'h710, 22, 0,  0, 1, 0,  0, 0, 0,        0,  0,   1,  0,  0, 'h700, 0, 1, 1};
      tv[27] = '{0, 0,     0,  0,  0, 0, 1,  0, 0, 0,        0,  0,   1,  1,  1, 'h700, 0, 1, 1};
      tv[28] = '{0, 0,     0,  0,  0, 0, 1,  0, 2, (23<<7),  0,  0,   1,  1,  1, 'h710, 0, 0, 1};
      tv[29] = '{0, 0,     0,  0,  0, 0, 0,  0, 0, 0,        0,  0,   1,  0,  0, 0,     0, 0, 0};

      reset = 1'b1;
      drive(mkv(1, 'h80, 1, 7, 0), 0);
      step();
      @(negedge clk);
      chk("rst_ready", 32'(bus.ready_in), 0);
      chk("rst_nr", 32'(bus.nr_valid_out), 0);
      chk("rst_we", 32'(bus.rob_we_out), 0);
      chk("rst_rsv", 32'(bus.rs_valid_out), 0);
      step();
      reset = 1'b0;
      drive(mkv(0, 0, 0, 7, 0), 0);
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.ready_in), 1);
      chk("post_rst_pc", bus.rob_pc_out, 0);
      chk("post_rst_rsdata_zero", 32'(bus.rs_data_out == '0), 1);
      chk("post_rst_we", 32'(bus.rob_we_out), 0);
      step();

      for (int i = 0; i < 30; i++) begin
         drive(tv[i], i);
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), 32'(bus.ready_in), 32'(tv[i].e_rdy));
         chk($sformatf("v%0d_rsv", i), 32'(bus.rs_valid_out), 32'(tv[i].e_rsv));
         chk($sformatf("v%0d_we", i), 32'(bus.rob_we_out), 32'(tv[i].e_we));
         chk($sformatf("v%0d_pc", i), bus.rob_pc_out, 32'(tv[i].e_pc));
         chk($sformatf("v%0d_nr", i), 32'(bus.nr_valid_out), 32'(tv[i].e_nr));
         if (tv[i].e_nr != 0) chk($sformatf("v%0d_nr_reg", i), 32'(bus.nr_reg_out), 32'(tv[i].pd));
         chk($sformatf("v%0d_r1", i), 32'(bus.rs_data_out.pr1_ready), 32'(tv[i].e_r1));
         chk($sformatf("v%0d_r2", i), 32'(bus.rs_data_out.pr2_ready), 32'(tv[i].e_r2));
         chk($sformatf("v%0d_rob_idx", i), 32'(bus.rs_data_out.rob_index), tv[i].e_pc != 0 ? 32'(i) : 0);
         step();
      end

      for (int k = 0; k < 3; k++) begin
         drive(mkv(1, 'h500 + 'h10 * k, 1, 7, 1), 0);
         step();
      end
      drive(mkv(1, 'h530, 1, 7, 0), 0);
      bus.mispredict = 1'b1;
      @(negedge clk);
      chk("flush_ready", 32'(bus.ready_in), 0);
      chk("flush_we", 32'(bus.rob_we_out), 0);
      chk("flush_rsv", 32'(bus.rs_valid_out), 0);
      chk("flush_nr", 32'(bus.nr_valid_out), 0);
      step();
      drive(mkv(0, 0, 0, 7, 0), 0);
      @(negedge clk);
      chk("post_flush_ready", 32'(bus.ready_in), 1);
      chk("post_flush_pc", bus.rob_pc_out, 0);
      chk("post_flush_we", 32'(bus.rob_we_out), 0);
      step();

      for (int k = 0; k < 2; k++) begin
         drive(mkv(1, 'h580 + 'h10 * k, 1, 7, 1), 0);
         step();
      end
      reset = 1'b1;
      drive(mkv(1, 'h5a0, 1, 7, 0), 0);
      bus.mispredict = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 32'(bus.ready_in), 0);
      chk("midrst_we", 32'(bus.rob_we_out), 0);
      chk("midrst_pc", bus.rob_pc_out, 0);
      chk("midrst_rsdata_zero", 32'(bus.rs_data_out == '0), 1);
      step();
      reset = 1'b0;
      drive(mkv(0, 0, 0, 7, 0), 0);
      @(negedge clk);
      chk("post_midrst_ready", 32'(bus.ready_in), 1);
      chk("post_midrst_pc", bus.rob_pc_out, 0);
      step();

      for (int k = 0; k < 3; k++) begin
         drive(mkv(1, 'h600 + 'h10 * k, 1, 1, 1), 0);
         step();
      end
      for (int k = 0; k < 6; k++) begin
         drive(mkv(1, 'h630 + 'h10 * k, 1, 1, 0), 0);
         @(negedge clk);
         chk($sformatf("wrap%0d_ready", k), 32'(bus.ready_in), 1);
         chk($sformatf("wrap%0d_we", k), 32'(bus.rob_we_out), 1);
         chk($sformatf("wrap%0d_pc", k), bus.rob_pc_out, 32'('h600 + 'h10 * k));
         step();
      end
      for (int k = 0; k < 3; k++) begin
         drive(mkv(0, 0, 0, 1, 0), 0);
         @(negedge clk);
         chk($sformatf("drain%0d_pc", k), bus.rob_pc_out, 32'('h660 + 'h10 * k));
         chk($sformatf("drain%0d_rsv", k), 32'(bus.rs_valid_out), 1);
         step();
      end
      @(negedge clk);
      chk("final_empty_pc", bus.rob_pc_out, 0);
      chk("final_empty_we", 32'(bus.rob_we_out), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised in-order dispatch stage between rename and the reservation stations. It holds up to DEPTH renamed instructions in a circular queue and snoops NUM_CDB completion tags every cycle so operand readiness is never lost while an entry waits. The head instruction is dispatched to one of NUM_FU reservation stations and allocated in the ROB in the same cycle, strictly in program order. Flush on mispredict.

## Interface
- DEPTH, 4: queue entries, ≥2, any value (not restricted to powers of two).
- NUM_FU, 3: reservation-station channels.
- NUM_CDB, 3: wakeup broadcast ports.
- PREG_W, 7: physical register tag width.
- ROB_W, 5: ROB tag width.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- valid_in  in  1  rename packet valid.
- data_in  in  rename_data  renamed instruction.
- fu_sel_in  in  NUM_FU  one-hot target channel; all-zero means ROB-only (no RS).
- ready_in  out  1  queue can accept.
- query_ps1 / query_ps2  out  PREG_W each  PRF readiness query, driven from data_in.
- pr1_is_ready / pr2_is_ready  in  1 each  PRF answers.
- nr_valid_out  out  1  mark destination busy.
- nr_reg_out  out  PREG_W  destination to mark busy.
- cdb_valid  in  NUM_CDB  broadcast valid per port.
- cdb_tag  in  NUM_CDB*PREG_W  flattened tags; port i at [i*PREG_W +: PREG_W].
- rs_valid_out  out  NUM_FU  per-channel write strobe.
- rs_data_out  out  dispatch_pipeline_data  shared payload for all channels.
- rs_ready_in  in  NUM_FU  per-channel space available.
- rob_we_out  out  1  ROB allocate.
- rob_pd_new_out / rob_pd_old_out  out  PREG_W each.
- rob_pc_out  out  32.
- rob_tag_in  in  ROB_W  tag the ROB assigns on this allocate.
- rob_full_in  in  1.
- mispredict  in  1  flush.

## Operation
- Enqueue when valid_in && ready_in. ready_in = !full && !reset && !mispredict.
- Each entry stores the packet, its fu_sel, and r1/r2 bits.
  - At enqueue, r = (ps==0) || pr_is_ready || any cdb_valid[i] with matching cdb_tag[i].
- Every cycle, each valid entry ORs in CDB matches on ps1/ps2.
- nr_valid_out = enqueue && pd_new != 0; nr_reg_out = data_in.pd_new.
- Dispatch the head when all of the following hold: count > 0, !rob_full_in, !mispredict, and either fu_sel is zero or rs_ready_in[sel] is high.
  - sel is the lowest set bit of fu_sel; multi-hot entries use the lowest set bit.
  - rs_valid_out[sel] = dispatch; all other bits are 0.
  - rob_we_out = dispatch.
- rs_data_out fields come from the head entry:
  - pc, Opcode, func3, func7, imm[31:0].
  - prd = pd_new, pr1 = ps1, pr2 = ps2.
  - rob_index = rob_tag_in.
  - pr1_ready / pr2_ready = stored bit OR same-cycle CDB match.
- rob_* data outputs always reflect the head entry, or 0 when empty.
- Simultaneous enqueue and dispatch when count < DEPTH: count unchanged, both pointers advance. When full, ready_in = 0 regardless of dispatch; there is no combinational path from rs_ready_in to ready_in.
- Pointers wrap from DEPTH-1 to 0. Count is $clog2(DEPTH+1) bits.
- mispredict (synchronous): head, tail and count go to 0. No enqueue, dispatch, nr or ROB strobe is asserted in that cycle.

## Timing
- Reset, and the first cycle after it, give count=0.
  - Strobe outputs: rs_valid_out, rob_we_out and nr_valid_out are 0.
  - Data outputs: rs_data_out and the rob_* data outputs are 0.
  - ready_in = 0 while reset is high and 1 the cycle after.
- Reset mid-operation discards all entries. It behaves like mispredict and has priority over it.
- Latency: an instruction enqueued in cycle N is dispatchable in cycle N+1 at the earliest.
- Throughput: 1 per cycle.
- A CDB tag in cycle N is visible in stored bits from N+1 and in rs_data_out in cycle N itself.

## Structure
- Add to types_pkg:
  - dispatch_pipeline_data, extended with ROB_W-agnostic rob_index.
  - function cdb_hit(tag, cdb_valid, cdb_tag) that loops over NUM_CDB.
- Per-entry state lives in unpacked arrays in this module, not in package typedefs, because the widths are parametric.
- No sub-module is needed; the queue and wakeup logic are one always_ff plus combinational head decode.

## Test plan
- Enqueue ALU op ps1=5, ps2=0, pr1_is_ready=0, then cdb tag 5 valid two cycles later, rs_ready_in=0 → once rs_ready_in=1, dispatch shows pr1_ready=1, pr2_ready=1.
- Fill DEPTH=4 entries with rob_full_in=1 → ready_in=0, no rob_we_out. Release rob_full_in → four dispatches on consecutive cycles, in order, tags = rob_tag_in each cycle.
- Head fu_sel=3'b010 with rs_ready_in=3'b101 → stall, and no younger entry bypasses it. Raise bit 1 → rs_valid_out=3'b010.
- fu_sel=0 entry → rob_we_out=1, rs_valid_out=0.
- mispredict with 3 entries queued and valid_in=1 → next cycle count=0, no strobes in the flush cycle, ready_in=1 after.
- Enqueue pd_new=0 → nr_valid_out=0. Enqueue pd_new=9 → nr_valid_out=1, nr_reg_out=9. Simultaneous push/pop at wrap → order preserved.
